cpu_run_monitor: RTL and testbench

Parametrised run controller and monitor that wraps a CPU under test (single- or multi-period core). It sequences the CPU reset for a programmable number of cycles and then lets the core run. While the core runs, it counts cycles and retired instructions and detects halt (PC stall or halt opcode) or timeout. Final status is latched for the bench or a debug port. It replaces the fixed "reset one period, run N periods, finish" sequence with one reusable block.

---
 rtl/cpu_run_monitor.sv | 171 +++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// Run controller and monitor for a CPU under test: sequences the CPU reset,
// counts run cycles and retired instructions, and latches halt/timeout status.
module cpu_run_monitor #(
    parameter int ADDR_LEN     = 32,
    parameter int INSTR_LEN    = 32,
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 1,
    parameter int MAX_CYCLES   = 100,
    parameter int STALL_LIMIT  = 16,
    parameter int HALT_EN      = 1,
    parameter logic [INSTR_LEN-1:0] HALT_INSTR = {INSTR_LEN{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_LEN-1:0]  pc,
    input  logic [INSTR_LEN-1:0] inst,
    output logic                 cpu_rst,
    output logic                 running,
    output logic                 done,
    output logic                 halted,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instr_cnt,
    output logic [ADDR_LEN-1:0]  final_pc
);

    localparam int RST_LOAD = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
    localparam logic [31:0]      RST_LOAD_V = 32'(RST_LOAD);
    localparam logic [CNT_W-1:0] MAX_M1     = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_M1   = CNT_W'(STALL_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_RUN     = 3'd2,
        S_HALTED  = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t              state_r;
    logic [31:0]         rst_cnt_r;
    logic [ADDR_LEN-1:0] prev_pc_r;
    logic [CNT_W-1:0]    stall_cnt_r;
    logic                first_r;

    logic pc_same_s;
    logic stall_hit_s;
    logic op_hit_s;
    logic halt_s;
    logic timeout_s;
    logic restart_s;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // End-of-run and restart conditions evaluated from the current RUN sample.
    always_comb begin
        pc_same_s   = (pc == prev_pc_r);
        stall_hit_s = !first_r && pc_same_s && (stall_cnt_r == STALL_M1);
        op_hit_s    = (HALT_EN != 0) && (inst == HALT_INSTR);
        halt_s      = stall_hit_s || op_hit_s;
        timeout_s   = (cycle_cnt == MAX_M1);
        restart_s   = start && ((state_r == S_IDLE) || (state_r == S_HALTED) ||
                                (state_r == S_TIMEOUT));
    end

    // Run sequencer with all status outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            rst_cnt_r   <= 32'd0;
            prev_pc_r   <= {ADDR_LEN{1'b0}};
            stall_cnt_r <= {CNT_W{1'b0}};
            first_r     <= 1'b0;
            cpu_rst     <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cycle_cnt   <= {CNT_W{1'b0}};
            instr_cnt   <= {CNT_W{1'b0}};
            final_pc    <= {ADDR_LEN{1'b0}};
        end else if (abort) begin
            // Counters and final_pc are deliberately kept for post-mortem reads.
            state_r <= S_IDLE;
            cpu_rst <= 1'b1;
            running <= 1'b0;
            done    <= 1'b0;
            halted  <= 1'b0;
            timeout <= 1'b0;
        end else if (restart_s) begin
            state_r     <= S_RESET;
            rst_cnt_r   <= RST_LOAD_V;
            stall_cnt_r <= {CNT_W{1'b0}};
            first_r     <= 1'b1;
            cpu_rst     <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cycle_cnt   <= {CNT_W{1'b0}};
            instr_cnt   <= {CNT_W{1'b0}};
            final_pc    <= {ADDR_LEN{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    cpu_rst <= 1'b1;
                end
                S_RESET: begin
                    if (rst_cnt_r <= 32'd1) begin
                        state_r <= S_RUN;
                        cpu_rst <= 1'b0;
                        running <= 1'b1;
                        first_r <= 1'b1;
                    end else begin
                        rst_cnt_r <= rst_cnt_r - 32'd1;
                    end
                end
                S_RUN: begin
                    cycle_cnt <= sat_inc(cycle_cnt);
                    prev_pc_r <= pc;
                    first_r   <= 1'b0;
                    // The first RUN sample only seeds prev_pc.
                    if (!first_r) begin
                        if (!pc_same_s) begin
                            instr_cnt   <= sat_inc(instr_cnt);
                            stall_cnt_r <= {CNT_W{1'b0}};
                        end else begin
                            stall_cnt_r <= sat_inc(stall_cnt_r);
                        end
                    end
                    if (halt_s) begin
                        state_r  <= S_HALTED;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        halted   <= 1'b1;
                        final_pc <= pc;
                    end else if (timeout_s) begin
                        state_r  <= S_TIMEOUT;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        final_pc <= pc;
                    end
                end
                S_HALTED, S_TIMEOUT: begin
                    cpu_rst <= 1'b0;
                    running <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    state_r <= S_IDLE;
                    cpu_rst <= 1'b1;
                    running <= 1'b0;
                    done    <= 1'b0;
                    halted  <= 1'b0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_cpu_run_monitor;

    localparam int RC  = 3;
    localparam int MAXC = 100;
    localparam int STL = 16;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [63:0] SAT = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [31:0] pc, inst;
    logic        cpu_rst, running, done, halted, timeout;
    logic [31:0] cycle_cnt, instr_cnt, final_pc;

    int n_checks = 0;
    int n_fail = 0;

    cpu_run_monitor #(
        .ADDR_LEN(32), .INSTR_LEN(32), .CNT_W(32), .RESET_CYCLES(RC),
        .MAX_CYCLES(MAXC), .STALL_LIMIT(STL), .HALT_EN(1), .HALT_INSTR(HALT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pc(pc), .inst(inst),
        .cpu_rst(cpu_rst), .running(running), .done(done), .halted(halted),
        .timeout(timeout), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
        .final_pc(final_pc)
    );

    always #5 clk = ~clk;

    // Behavioural model: run phase, how many reset cycles remain, and how long
    // the PC has currently been sitting still.
    localparam int P_IDLE = 0, P_RESET = 1, P_RUN = 2, P_HALT = 3, P_TO = 4;
    int          m_phase = P_IDLE;
    int          m_left = 0;
    int          m_still = 0;
    bit          m_first = 1'b0;
    logic [63:0] m_cyc = 64'd0, m_instr = 64'd0;
    logic [31:0] m_last = 32'd0, m_fpc = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_left = 0; m_still = 0; m_first = 1'b0;
        m_cyc = 64'd0; m_instr = 64'd0; m_last = 32'd0; m_fpc = 32'd0;
    endtask

    task automatic model_step();
        bit hit_halt, hit_to;
        if (abort) begin
            m_phase = P_IDLE;
        end else if (start && (m_phase == P_IDLE || m_phase == P_HALT || m_phase == P_TO)) begin
            m_phase = P_RESET; m_left = RC; m_still = 0;
            m_cyc = 64'd0; m_instr = 64'd0; m_fpc = 32'd0;
        end else if (m_phase == P_RESET) begin
            m_left--;
            if (m_left == 0) begin
                m_phase = P_RUN;
                m_first = 1'b1;
            end
        end else if (m_phase == P_RUN) begin
            if (m_cyc != SAT) m_cyc = m_cyc + 64'd1;
            if (m_first) begin
                m_still = 0;
            end else if (pc != m_last) begin
                if (m_instr != SAT) m_instr = m_instr + 64'd1;
                m_still = 0;
            end else begin
                m_still++;
            end
            m_first = 1'b0;
            m_last = pc;
            hit_halt = (inst == HALT) || (m_still == STL);
            hit_to = (m_cyc == 64'(MAXC));
            if (hit_halt) begin
                m_phase = P_HALT; m_fpc = pc;
            end else if (hit_to) begin
                m_phase = P_TO; m_fpc = pc;
            end
        end
    endtask

    // Model advances on the same edges the DUT sees.
    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step();
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("cpu_rst", 64'(cpu_rst), 64'(m_phase == P_IDLE || m_phase == P_RESET));
        check("running", 64'(running), 64'(m_phase == P_RUN));
        check("done", 64'(done), 64'(m_phase == P_HALT || m_phase == P_TO));
        check("halted", 64'(halted), 64'(m_phase == P_HALT));
        check("timeout", 64'(timeout), 64'(m_phase == P_TO));
        check("cycle_cnt", 64'(cycle_cnt), m_cyc);
        check("instr_cnt", 64'(instr_cnt), m_instr);
        check("final_pc", 64'(final_pc), 64'(m_fpc));
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_running();
        int n = 0;
        while (running !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (running !== 1'b1) check("wait_running", 64'(running), 64'd1);
    endtask

    initial begin
        int n;
        int hold_pct;
        rst = 1'b1; start = 1'b0; abort = 1'b0; pc = 32'd0; inst = 32'd0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_cpu_rst", 64'(cpu_rst), 64'd1);
        check("idle_done", 64'(done), 64'd0);
        check("idle_cycle_cnt", 64'(cycle_cnt), 64'd0);

        // Reset sequencing, then PC steps by 4 every 4 cycles and parks at 0x40.
        pc = 32'd0;
        pulse_start();
        check("reset_c1_cpu_rst", 64'(cpu_rst), 64'd1);
        check("reset_c1_running", 64'(running), 64'd0);
        repeat (2) @(negedge clk);
        check("reset_c3_cpu_rst", 64'(cpu_rst), 64'd1);
        @(negedge clk);
        check("run_c4_running", 64'(running), 64'd1);
        check("run_c4_cpu_rst", 64'(cpu_rst), 64'd0);
        for (int k = 0; k <= 80; k++) begin
            pc = (k >= 64) ? 32'h40 : 32'((k / 4) * 4);
            @(negedge clk);
        end
        check("stall_halted", 64'(halted), 64'd1);
        check("stall_timeout", 64'(timeout), 64'd0);
        check("stall_final_pc", 64'(final_pc), 64'h40);
        check("stall_instr_cnt", 64'(instr_cnt), 64'd16);
        check("stall_cycle_cnt", 64'(cycle_cnt), 64'd81);

        // PC never stalls: timeout when cycle_cnt reaches 100, then frozen.
        pulse_start();
        wait_running();
        for (int k = 0; k < 100; k++) begin
            pc = 32'(k);
            @(negedge clk);
        end
        check("to_timeout", 64'(timeout), 64'd1);
        check("to_halted", 64'(halted), 64'd0);
        check("to_done", 64'(done), 64'd1);
        check("to_cycle_cnt", 64'(cycle_cnt), 64'd100);
        check("to_instr_cnt", 64'(instr_cnt), 64'd99);
        check("to_final_pc", 64'(final_pc), 64'd99);
        repeat (5) @(negedge clk);
        check("to_frozen_cycle_cnt", 64'(cycle_cnt), 64'd100);

        // Halt opcode coincides with the timeout cycle: halt wins.
        pulse_start();
        wait_running();
        for (int k = 0; k < 100; k++) begin
            pc = 32'(k);
            inst = (k == 99) ? HALT : 32'd0;
            @(negedge clk);
        end
        inst = 32'd0;
        check("tie_halted", 64'(halted), 64'd1);
        check("tie_timeout", 64'(timeout), 64'd0);
        check("tie_cycle_cnt", 64'(cycle_cnt), 64'd100);
        pulse_start();
        check("restart_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("restart_instr_cnt", 64'(instr_cnt), 64'd0);

        // Asynchronous reset in the middle of a run.
        wait_running();
        n = 0;
        while (cycle_cnt != 32'd37 && n < 200) begin
            pc = pc + 32'd1;
            @(negedge clk);
            n++;
        end
        check("reach_37", 64'(cycle_cnt), 64'd37);
        #2 rst = 1'b0;
        #1;
        check("arst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("arst_running", 64'(running), 64'd0);
        check("arst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("arst_instr_cnt", 64'(instr_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Abort mid-run: back to idle with counters held.
        pulse_start();
        wait_running();
        n = 0;
        while (cycle_cnt != 32'd20 && n < 200) begin
            pc = pc + 32'd4;
            @(negedge clk);
            n++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_cpu_rst", 64'(cpu_rst), 64'd1);
        check("abort_running", 64'(running), 64'd0);
        check("abort_cycle_cnt", 64'(cycle_cnt), 64'd20);

        // Randomized traffic; the every-cycle compare does the checking.
        hold_pct = 60;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0: hold_pct = 20;
                    1: hold_pct = 60;
                    default: hold_pct = 97;
                endcase
            end
            start = ($urandom_range(0, 24) == 0);
            abort = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 99) >= hold_pct)
                pc = ($urandom_range(0, 3) == 0) ? $urandom : pc + 32'd4;
            inst = ($urandom_range(0, 299) == 0) ? HALT : {1'b0, 31'($urandom)};
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
